rns_residue_sequencer: RTL and testbench

Sequencing controller that converts a 4-bit binary operand into a 3-channel residue number system (RNS) word by time-sharing one external combinational modulus unit (4-bit dividend, 3-bit moduli, 3-bit remainder) across three fixed moduli. It accepts operands over a valid/ready handshake and drives the shared unit one channel per cycle. It collects the remainders and presents the residue vector over a second valid/ready handshake. It sits between the binary front end and the RNS arithmetic channels.

---
 rtl/rns_residue_sequencer.sv | 136 +++++++++++++
 tb/tb_rns_residue_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rns_residue_sequencer.sv
// rtl/rns_residue_sequencer.sv - binary-to-RNS converter time-sharing one external modulus unit
// Walks the enabled channels lowest-first, one shared-unit request per cycle.
module rns_residue_sequencer #(
   parameter int MOD0 = 3,
   parameter int MOD1 = 5,
   parameter int MOD2 = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic [2:0] in_mask,
   output logic [3:0] mod_dividend,
   output logic [2:0] mod_moduli,
   input  logic [2:0] mod_remainder,
   output logic       mod_active,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [2:0] res0,
   output logic [2:0] res1,
   output logic [2:0] res2,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      operand_q, operand_d;
   logic [2:0]      mask_q, mask_d;
   logic [1:0]      idx_q, idx_d;
   logic [2:0][2:0] res_q, res_d;
   logic [3:0]      mod_dividend_q, mod_dividend_d;
   logic [2:0]      mod_moduli_q, mod_moduli_d;
   logic            mod_active_q, mod_active_d;
   logic [2:0]      nxt;

   function automatic logic [2:0] modulus(input logic [1:0] i);
      case (i)
         2'd0:    return 3'(MOD0);
         2'd1:    return 3'(MOD1);
         default: return 3'(MOD2);
      endcase
   endfunction

   // Returns {found, index} of the lowest set mask bit at or above lo.
   function automatic logic [2:0] first_set_from(input logic [2:0] m, input int lo);
      logic [2:0] r;
      r = 3'b000;
      for (int k = 2; k >= 0; k--) begin
         if (k >= lo && m[k]) r = {1'b1, 2'(k)};
      end
      return r;
   endfunction

   always_comb begin
      state_d        = state_q;
      operand_d      = operand_q;
      mask_d         = mask_q;
      idx_d          = idx_q;
      res_d          = res_q;
      mod_dividend_d = mod_dividend_q;
      mod_moduli_d   = mod_moduli_q;
      mod_active_d   = mod_active_q;
      nxt            = 3'b000;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               operand_d = in_data;
               mask_d    = in_mask;
               res_d     = '0;
               nxt       = first_set_from(in_mask, 0);
               if (nxt[2]) begin
                  state_d        = RUN;
                  idx_d          = nxt[1:0];
                  mod_dividend_d = in_data;
                  mod_moduli_d   = modulus(nxt[1:0]);
                  mod_active_d   = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            res_d[idx_q] = mod_remainder;
            nxt          = first_set_from(mask_q, int'(idx_q) + 1);
            if (nxt[2]) begin
               idx_d        = nxt[1:0];
               mod_moduli_d = modulus(nxt[1:0]);
            end else begin
               state_d        = DONE;
               mod_dividend_d = 4'd0;
               mod_moduli_d   = 3'd0;
               mod_active_d   = 1'b0;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         operand_q      <= 4'd0;
         mask_q         <= 3'd0;
         idx_q          <= 2'd0;
         res_q          <= '0;
         mod_dividend_q <= 4'd0;
         mod_moduli_q   <= 3'd0;
         mod_active_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         operand_q      <= operand_d;
         mask_q         <= mask_d;
         idx_q          <= idx_d;
         res_q          <= res_d;
         mod_dividend_q <= mod_dividend_d;
         mod_moduli_q   <= mod_moduli_d;
         mod_active_q   <= mod_active_d;
      end
   end

   assign in_ready     = (state_q == IDLE) && !rst;
   assign res_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign mod_dividend = mod_dividend_q;
   assign mod_moduli   = mod_moduli_q;
   assign mod_active   = mod_active_q;
   assign res0         = res_q[0];
   assign res1         = res_q[1];
   assign res2         = res_q[2];

endmodule

// File: tb/tb_rns_residue_sequencer.sv
// tb/tb_rns_residue_sequencer.sv - bench for rns_residue_sequencer
module tb_rns_residue_sequencer;

   localparam int M0 = 3;
   localparam int M1 = 5;
   localparam int M2 = 7;

   logic       clk = 0;
   logic       rst = 1;
   logic       in_valid = 0;
   logic       in_ready;
   logic [3:0] in_data = 0;
   logic [2:0] in_mask = 0;
   logic [3:0] mod_dividend;
   logic [2:0] mod_moduli;
   logic [2:0] mod_remainder;
   logic       mod_active;
   logic       res_valid;
   logic       res_ready = 0;
   logic [2:0] res0, res1, res2;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   int         obs_timeout, obs_lat, obs_div_bad, obs_bp_bad, obs_accept_cyc, obs_nmods;
   logic [8:0] obs_seq, obs_res, obs_after_res;
   logic       obs_after_valid, obs_after_ready, obs_done_mod_idle;
   logic       active_seen;

   rns_residue_sequencer #(.MOD0(M0), .MOD1(M1), .MOD2(M2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mask(in_mask), .mod_dividend(mod_dividend),
      .mod_moduli(mod_moduli), .mod_remainder(mod_remainder), .mod_active(mod_active),
      .res_valid(res_valid), .res_ready(res_ready), .res0(res0), .res1(res1),
      .res2(res2), .busy(busy)
   );

   // Shared combinational modulus unit.
   assign mod_remainder = (mod_moduli == 3'd0) ? 3'd0 : 3'(mod_dividend % mod_moduli);

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mod_active) active_seen <= 1'b1;
   end

   initial begin
      assert (M0 >= 2 && M0 <= 7 && M1 >= 2 && M1 <= 7 && M2 >= 2 && M2 <= 7)
         else $fatal(1, "FAIL modulus parameter outside 2..7");
   end

   function automatic int modv(input int i);
      return (i == 0) ? M0 : (i == 1) ? M1 : M2;
   endfunction

   function automatic logic [8:0] exp_res(input int d, input logic [2:0] m);
      logic [8:0] r;
      r = '0;
      for (int i = 0; i < 3; i++) if (m[i]) r[i*3 +: 3] = 3'(d % modv(i));
      return r;
   endfunction

   function automatic logic [8:0] exp_seq(input logic [2:0] m);
      logic [8:0] s;
      s = '0;
      for (int i = 0; i < 3; i++) if (m[i]) s = {s[5:0], 3'(modv(i))};
      return s;
   endfunction

   function automatic int popc(input logic [2:0] m);
      return int'(m[0]) + int'(m[1]) + int'(m[2]);
   endfunction

   task automatic run_op(input logic [3:0] d, input logic [2:0] m, input int hold);
      int c, w;
      res_ready   = (hold == 0);
      w           = 0;
      obs_timeout = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 20) begin
         obs_timeout = 1;
         return;
      end
      in_data = d; in_mask = m; in_valid = 1;
      @(posedge clk); #1;
      obs_accept_cyc = cyc;
      in_valid = 0;
      obs_seq = '0; obs_nmods = 0; obs_div_bad = 0; c = 1;
      while (!res_valid && c <= 20) begin
         if (mod_active) begin
            obs_seq = {obs_seq[5:0], mod_moduli};
            obs_nmods++;
            if (mod_dividend !== d) obs_div_bad = 1;
         end
         @(posedge clk); #1; c++;
      end
      obs_lat = res_valid ? c : -1;
      obs_res = {res2, res1, res0};
      obs_done_mod_idle = !mod_active && mod_moduli == 0 && mod_dividend == 0;
      obs_bp_bad = 0;
      if (hold > 0) begin
         in_valid = 1; in_data = ~d; in_mask = 3'b111;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!res_valid || in_ready || {res2, res1, res0} !== obs_res) obs_bp_bad = 1;
         end
         in_valid = 0; res_ready = 1;
      end
      @(posedge clk); #1;
      obs_after_valid = res_valid;
      obs_after_ready = in_ready;
      obs_after_res   = {res2, res1, res0};
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({res_valid, mod_active, busy, in_ready} !== 4'b0000 || mod_dividend !== 0 || mod_moduli !== 0
          || {res2, res1, res0} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_state got valid=%b active=%b busy=%b ready=%b res=%h exp all zero",
                  res_valid, mod_active, busy, in_ready, {res2, res1, res0});
      end
      rst = 0;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_basic;
      run_op(4'd13, 3'b111, 0);
      vectors++;
      if (obs_timeout != 0 || obs_lat != 4 || obs_seq !== {3'd3, 3'd5, 3'd7} || obs_div_bad != 0) begin
         miscompares++;
         $display("FAIL basic_13_timing got lat=%0d seq=%h divbad=%0d exp lat=4 seq=%h",
                  obs_lat, obs_seq, obs_div_bad, {3'd3, 3'd5, 3'd7});
      end
      vectors++;
      if (obs_res !== {3'd6, 3'd3, 3'd1} || !obs_done_mod_idle) begin
         miscompares++;
         $display("FAIL basic_13_res got %h modidle=%b exp %h", obs_res, obs_done_mod_idle, {3'd6, 3'd3, 3'd1});
      end
      vectors++;
      if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1 || obs_after_res !== obs_res) begin
         miscompares++;
         $display("FAIL basic_13_handshake got valid=%b ready=%b res=%h exp 0 1 %h",
                  obs_after_valid, obs_after_ready, obs_after_res, obs_res);
      end
      run_op(4'd15, 3'b111, 0);
      vectors++;
      if (obs_res !== {3'd1, 3'd0, 3'd0}) begin
         miscompares++;
         $display("FAIL basic_15_res got %h exp %h", obs_res, {3'd1, 3'd0, 3'd0});
      end
   endtask

   task automatic test_sweep;
      for (int d = 0; d < 16; d++) begin
         run_op(4'(d), 3'b111, 0);
         vectors++;
         if (obs_lat != 4 || obs_res !== exp_res(d, 3'b111)) begin
            miscompares++;
            $display("FAIL sweep_d%0d got lat=%0d res=%h exp lat=4 res=%h", d, obs_lat, obs_res, exp_res(d, 3'b111));
         end
      end
   endtask

   task automatic test_mask_101;
      run_op(4'd9, 3'b101, 0);
      vectors++;
      if (obs_lat != 3 || obs_nmods != 2 || obs_seq !== {3'd0, 3'd3, 3'd7} || obs_res !== {3'd2, 3'd0, 3'd0}) begin
         miscompares++;
         $display("FAIL mask_101 got lat=%0d n=%0d seq=%h res=%h exp lat=3 n=2 seq=%h res=%h",
                  obs_lat, obs_nmods, obs_seq, obs_res, {3'd0, 3'd3, 3'd7}, {3'd2, 3'd0, 3'd0});
      end
   endtask

   task automatic test_mask_000;
      active_seen = 0;
      run_op(4'd11, 3'b000, 0);
      vectors++;
      if (obs_lat != 1 || obs_res !== 9'd0 || active_seen !== 1'b0) begin
         miscompares++;
         $display("FAIL mask_000 got lat=%0d res=%h active_seen=%b exp lat=1 res=0 active_seen=0",
                  obs_lat, obs_res, active_seen);
      end
   endtask

   task automatic test_backpressure;
      logic [3:0] d;
      d = 4'($urandom_range(0, 15));
      run_op(d, 3'b111, 5);
      vectors++;
      if (obs_bp_bad != 0 || obs_res !== exp_res(d, 3'b111)) begin
         miscompares++;
         $display("FAIL backpressure got bad=%0d res=%h exp bad=0 res=%h", obs_bp_bad, obs_res, exp_res(d, 3'b111));
      end
      vectors++;
      if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1 || obs_after_res !== exp_res(d, 3'b111)) begin
         miscompares++;
         $display("FAIL backpressure_release got valid=%b ready=%b res=%h exp 0 1 %h",
                  obs_after_valid, obs_after_ready, obs_after_res, exp_res(d, 3'b111));
      end
   endtask

   task automatic test_random;
      logic [3:0] d;
      logic [2:0] m;
      int         h;
      for (int i = 0; i < 40; i++) begin
         d = 4'($urandom_range(0, 15));
         m = 3'($urandom_range(0, 7));
         h = $urandom_range(0, 3);
         run_op(d, m, h);
         vectors++;
         if (obs_timeout != 0 || obs_lat != popc(m) + 1 || obs_seq !== exp_seq(m) || obs_res !== exp_res(d, m)
             || obs_bp_bad != 0 || obs_after_res !== exp_res(d, m)) begin
            miscompares++;
            $display("FAIL random_%0d d=%0d m=%b got lat=%0d seq=%h res=%h bp=%0d exp lat=%0d seq=%h res=%h",
                     i, d, m, obs_lat, obs_seq, obs_res, obs_bp_bad, popc(m) + 1, exp_seq(m), exp_res(d, m));
         end
      end
   endtask

   task automatic test_back_to_back;
      int first;
      run_op(4'd7, 3'b011, 0);
      first = obs_accept_cyc;
      run_op(4'd4, 3'b110, 0);
      vectors++;
      if (obs_accept_cyc - first != 4 || obs_res !== exp_res(4, 3'b110)) begin
         miscompares++;
         $display("FAIL back_to_back got interval=%0d res=%h exp interval=4 res=%h",
                  obs_accept_cyc - first, obs_res, exp_res(4, 3'b110));
      end
   endtask

   task automatic test_mid_reset;
      res_ready = 1;
      in_data = 4'd13; in_mask = 3'b111; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || mod_active !== 1'b0 || res_valid !== 1'b0 || {res2, res1, res0} !== 9'd0
          || mod_moduli !== 0 || mod_dividend !== 0) begin
         miscompares++;
         $display("FAIL mid_reset got busy=%b active=%b valid=%b res=%h exp all zero",
                  busy, mod_active, res_valid, {res2, res1, res0});
      end
      rst = 0;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_ready got %b exp 1", in_ready);
      end
      run_op(4'd10, 3'b111, 0);
      vectors++;
      if (obs_lat != 4 || obs_res !== exp_res(10, 3'b111)) begin
         miscompares++;
         $display("FAIL mid_reset_recover got lat=%0d res=%h exp lat=4 res=%h", obs_lat, obs_res, exp_res(10, 3'b111));
      end
   endtask

   initial begin
      active_seen = 0;
      test_reset();
      test_basic();
      test_sweep();
      test_mask_101();
      test_mask_000();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
